load_store_unit: RTL and testbench

//  Sits between the datapath memory stage and dmem, which only does word-aligned 32-bit accesses.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-only dmem.
// Sub-word stores are done as a read-modify-write. Sub-word loads are extended to 32 bits.
module load_store_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t       r_state;
    state_t       w_next_state;

    logic         r_resp_valid;
    logic [n-1:0] r_resp_rdata;
    logic         r_resp_err;
    logic [n-1:0] r_addr;
    logic [1:0]   r_lane;
    logic [1:0]   r_size;
    logic [n-1:0] r_wdata;
    logic [n-1:0] r_old;

    logic         w_accept;
    logic         w_misalign;
    logic         w_capture;
    logic         w_we_raw;
    logic         w_resp_valid_d;
    logic [n-1:0] w_resp_rdata_d;
    logic         w_resp_err_d;

    // Select the addressed lane of a word and sign- or zero-extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{b[7] & ~uns}}, b};
            SZ_HALF: res = {{16{h[15] & ~uns}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the target lane of the old word with the low bits of the store data.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [1:0] lane,
                                            input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] res;
        res = old;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res        = old;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0]  = wdata[15:0];
                end
            end
            default: res = old;
        endcase
        return res;
    endfunction

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_valid & req_ready;
    assign w_misalign = (req_size == 2'b11)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

    // Reset overrides the write strobe so a pending merge never lands in memory.
    assign mem_we     = w_we_raw & reset_n;

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    // Next-state, memory-port and response-data decode.
    always_comb begin
        w_next_state   = r_state;
        w_we_raw       = 1'b0;
        mem_addr       = {req_addr[n-1:2], 2'b00};
        mem_wdata      = req_wdata;
        w_resp_valid_d = 1'b0;
        w_resp_rdata_d = '0;
        w_resp_err_d   = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_rdata_d = f_extract(mem_rdata, req_addr[1:0], req_size, req_unsigned);
                    end else if (req_size == SZ_WORD) begin
                        w_we_raw       = 1'b1;
                        w_resp_valid_d = 1'b1;
                    end else begin
                        w_capture      = 1'b1;
                        w_next_state   = ST_MERGE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MERGE: begin
                w_we_raw       = 1'b1;
                mem_addr       = r_addr;
                mem_wdata      = f_merge(r_old, r_lane, r_size, r_wdata);
                w_resp_valid_d = 1'b1;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Response registers and the holding registers for a pending merge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_addr       <= '0;
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_wdata      <= '0;
            r_old        <= '0;
        end else begin
            r_resp_valid <= w_resp_valid_d;
            r_resp_rdata <= w_resp_rdata_d;
            r_resp_err   <= w_resp_err_d;
            if (w_capture) begin
                r_addr  <= {req_addr[n-1:2], 2'b00};
                r_lane  <= req_addr[1:0];
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_old   <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a word-array memory model with arithmetic lane rules.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bk_we;
    int          bk_idx;
    logic [31:0] bk_data;

    int n_cmp;
    int n_fail;

    load_store_unit #(.n(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
        else if (bk_we) dmem[bk_idx] <= bk_data;
    end

    function automatic bit ref_misaligned(input bit [31:0] a, input int sz);
        if (sz == 3) return 1'b1;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic bit [31:0] ref_load(input bit [31:0] w, input bit [31:0] a, input int sz, input bit uns);
        bit [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit [31:0] ref_store(input bit [31:0] w, input bit [31:0] a, input int sz, input bit [31:0] d);
        bit [31:0] mask;
        int        sh;
        if (sz == 2) return d;
        mask = (sz == 0) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    task automatic poke(input int idx, input bit [31:0] v);
        bk_we = 1'b1; bk_idx = idx; bk_data = v;
        @(posedge clk); #1;
        bk_we = 1'b0;
        ref_mem[idx] = v;
        #1;
    endtask

    // Issue one request and observe it to completion (bounded).
    task automatic run_req(input bit wr, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                           input bit [31:0] d, output int lat, output bit [31:0] rd,
                           output bit er, output int we_cnt, output int nr_cnt);
        int guard;
        lat = -1; rd = 32'h0; er = 1'b0; we_cnt = 0; nr_cnt = 0; guard = 0;
        while (!req_ready && guard < 8) begin
            @(posedge clk); #2;
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        #1;
        if (mem_we) we_cnt++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        for (int c = 1; c <= 6; c++) begin
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            if (mem_we) we_cnt++;
            if (!req_ready) nr_cnt++;
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%h e=%0b, want 0/0/0", resp_valid, resp_rdata, resp_err);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h24; req_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_we_forced: got %0b want 0", mem_we);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_loads();
        bit [31:0] addrs [4];
        bit        unss  [4];
        bit [1:0]  szs   [4];
        bit [31:0] exps  [4];
        int lat, wc, nr; bit [31:0] rd; bit er;
        addrs = '{32'h10, 32'h13, 32'h12, 32'h10};
        unss  = '{1'b0, 1'b1, 1'b0, 1'b1};
        szs   = '{2'b00, 2'b00, 2'b01, 2'b01};
        exps  = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8070, 32'h0000_60F0};
        poke(4, 32'h8070_60F0);
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, szs[i], unss[i], addrs[i], 32'hFFFF_FFFF, lat, rd, er, wc, nr);
            n_cmp++;
            if (rd !== exps[i] || lat != 1 || er !== 1'b0 || wc != 0) begin
                n_fail++;
                $display("FAIL load_%0d: got d=%h lat=%0d e=%0b we=%0d, want d=%h lat=1 e=0 we=0",
                         i, rd, lat, er, wc, exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        int lat, wc, nr; bit [31:0] rd; bit er;
        poke(8, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, lat, rd, er, wc, nr);
        n_cmp++;
        if (lat != 2 || nr != 1 || wc != 1 || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_timing: got lat=%0d notready=%0d we=%0d d=%h e=%0b, want 2/1/1/0/0", lat, nr, wc, rd, er);
        end
        n_cmp++;
        if (dmem[8] !== 32'h1122_AB44) begin
            n_fail++;
            $display("FAIL sb_data: got %h want 1122ab44", dmem[8]);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_pulse: resp_valid got %0b want 0", resp_valid);
        end
        poke(8, 32'h1122_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, rd, er, wc, nr);
        n_cmp++;
        if (dmem[8] !== 32'hBEEF_3344 || lat != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_data: got %h lat=%0d want beef3344 lat=2", dmem[8], lat);
        end
        run_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEAD_BEEF, lat, rd, er, wc, nr);
        n_cmp++;
        if (dmem[9] !== 32'hDEAD_BEEF || lat != 1 || wc != 1 || nr != 0 || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sw: got mem=%h lat=%0d we=%0d notready=%0d d=%h e=%0b, want deadbeef 1/1/0/0/0",
                     dmem[9], lat, wc, nr, rd, er);
        end
        ref_mem[8] = 32'hBEEF_3344;
        ref_mem[9] = 32'hDEAD_BEEF;
    endtask

    task automatic test_misaligned();
        bit [31:0] addrs [4];
        bit [1:0]  szs   [4];
        bit        wrs   [4];
        int lat, wc, nr; bit [31:0] rd; bit er;
        addrs = '{32'h13, 32'h26, 32'h20, 32'h11};
        szs   = '{2'b01, 2'b10, 2'b11, 2'b01};
        wrs   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_req(wrs[i], szs[i], 1'b0, addrs[i], 32'hCAFE_F00D, lat, rd, er, wc, nr);
            n_cmp++;
            if (er !== 1'b1 || rd !== 32'h0 || wc != 0 || lat != 1 || dmem[addrs[i] / 4] !== ref_mem[addrs[i] / 4]) begin
                n_fail++;
                $display("FAIL misaligned_%0d: got e=%0b d=%h we=%0d lat=%0d mem=%h, want 1/0/0/1 mem=%h",
                         i, er, rd, wc, lat, dmem[addrs[i] / 4], ref_mem[addrs[i] / 4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit [31:0] exps [3];
        for (int i = 0; i < 3; i++) exps[i] = ref_mem[4 + i];
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
                req_addr = 32'h10 + 32'(4 * i);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %0b want 1", i, req_ready);
            end
            if (i > 0) begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_rdata !== exps[i-1] || resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_resp_%0d: got v=%0b d=%h e=%0b, want 1/%h/0",
                             i - 1, resp_valid, resp_rdata, resp_err, exps[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        #1;
    endtask

    task automatic test_reset_in_merge();
        int lat, wc, nr; bit [31:0] rd; bit er;
        poke(8, 32'h1122_3344);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL merge_entry: got we=%0b ready=%0b want 1/0", mem_we, req_ready);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL merge_reset_we: got %0b want 0", mem_we);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL merge_reset_outputs: got v=%0b d=%h e=%0b r=%0b want 0/0/0/1",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (resp_valid !== 1'b0 || dmem[8] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL merge_dropped: got v=%0b mem=%h want 0/11223344", resp_valid, dmem[8]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, wc, nr);
        n_cmp++;
        if (rd !== 32'h1122_3344 || lat != 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_load: got d=%h lat=%0d e=%0b want 11223344/1/0", rd, lat, er);
        end
    endtask

    task automatic test_random();
        int lat, wc, nr, idx, sz, exp_lat, exp_we, exp_nr;
        bit [31:0] rd, a, d, exp_rd;
        bit er, wr, uns, bad;
        for (int k = 0; k < 300; k++) begin
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = int'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 255));
            d   = $urandom;
            idx = int'(a / 4);
            bad = ref_misaligned(a, sz);
            exp_rd  = (!bad && !wr) ? ref_load(ref_mem[idx], a, sz, uns) : 32'h0;
            exp_lat = (!bad && wr && sz != 2) ? 2 : 1;
            exp_nr  = exp_lat - 1;
            exp_we  = (!bad && wr) ? 1 : 0;
            if (!bad && wr) ref_mem[idx] = ref_store(ref_mem[idx], a, sz, d);
            run_req(wr, 2'(sz), uns, a, d, lat, rd, er, wc, nr);
            n_cmp++;
            if (rd !== exp_rd || er !== bad || lat != exp_lat || wc != exp_we || nr != exp_nr) begin
                n_fail++;
                $display("FAIL rand_%0d wr=%0b sz=%0d a=%h: got d=%h e=%0b lat=%0d we=%0d nr=%0d, want d=%h e=%0b lat=%0d we=%0d nr=%0d",
                         k, wr, sz, a, rd, er, lat, wc, nr, exp_rd, bad, exp_lat, exp_we, exp_nr);
            end
            n_cmp++;
            if (dmem[idx] !== ref_mem[idx]) begin
                n_fail++;
                $display("FAIL rand_mem_%0d a=%h: got %h want %h", k, a, dmem[idx], ref_mem[idx]);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        clk = 1'b0; reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        bk_we = 1'b0; bk_idx = 0; bk_data = 32'h0;
        @(posedge clk); #2;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_in_merge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
